// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states and divider depth.
package mdu_pkg;

    localparam int DIV_STEPS = 32;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mduState_t;

    function automatic logic isMulOp(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative restoring divider: one quotient bit per step, sign-corrected result presented with the done pulse.
module mdu_div
    import mdu_pkg::*;
#(
    parameter int STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividendMag,
    input  logic [31:0] divisorMag,
    input  logic [31:0] dividendRaw,
    input  logic        quoNeg,
    input  logic        remNeg,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    logic [31:0]      rem_r;
    logic [31:0]      quo_r;
    logic [31:0]      dvs_r;
    logic [31:0]      raw_r;
    logic [CNT_W-1:0] count_r;
    logic             quoNeg_r;
    logic             remNeg_r;
    logic             zero_r;

    logic [32:0] shifted_s;
    logic        fits_s;
    logic [31:0] nextRem_s;
    logic [31:0] nextQuo_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted_s = {rem_r, quo_r[31]};
        fits_s    = (shifted_s >= {1'b0, dvs_r});
        nextQuo_s = {quo_r[30:0], fits_s};
        if (fits_s) begin
            nextRem_s = shifted_s[31:0] - dvs_r;
        end else begin
            nextRem_s = shifted_s[31:0];
        end
    end

    // Final step: divide-by-zero bypass, otherwise sign-correct the magnitudes.
    always_comb begin
        done = step && (count_r == LAST_STEP);
        if (zero_r) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = raw_r;
        end else begin
            quotient  = quoNeg_r ? (32'd0 - nextQuo_s) : nextQuo_s;
            remainder = remNeg_r ? (32'd0 - nextRem_s) : nextRem_s;
        end
    end

    // Operand latch on start, then one restoring iteration per enabled step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            dvs_r    <= 32'd0;
            raw_r    <= 32'd0;
            count_r  <= '0;
            quoNeg_r <= 1'b0;
            remNeg_r <= 1'b0;
            zero_r   <= 1'b0;
        end else if (start) begin
            rem_r    <= 32'd0;
            quo_r    <= dividendMag;
            dvs_r    <= divisorMag;
            raw_r    <= dividendRaw;
            count_r  <= '0;
            quoNeg_r <= quoNeg;
            remNeg_r <= remNeg;
            zero_r   <= (divisorMag == 32'd0);
        end else if (step) begin
            rem_r   <= nextRem_s;
            quo_r   <= nextQuo_s;
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences MULT/DIV and holds the pipeline through MDUReadyE.
module mdu
    import mdu_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MDUOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        MemStall,
    input  logic        ExceptDealM,
    output logic        MDUReadyE,
    output logic [31:0] HiE,
    output logic [31:0] LoE
);

    mduState_t state_r;
    mduState_t nextState_s;

    logic [31:0] rHi_r;
    logic [31:0] rLo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        advance_s;
    logic [63:0] extA_s;
    logic [63:0] extB_s;
    logic [63:0] product_s;
    logic        aNeg_s;
    logic        bNeg_s;
    logic [31:0] magA_s;
    logic [31:0] magB_s;
    logic        divStart_s;
    logic        divStep_s;
    logic        divDone_s;
    logic [31:0] divQuo_s;
    logic [31:0] divRem_s;

    // The low 64 bits of a 64x64 product equal the 32x32 result once operands are extended by signedness.
    always_comb begin
        advance_s = !MemStall && !ExceptDealM;
        if (MDUOpE == MDU_MULT) begin
            extA_s = {{32{SrcAE[31]}}, SrcAE};
            extB_s = {{32{SrcBE[31]}}, SrcBE};
        end else begin
            extA_s = {32'd0, SrcAE};
            extB_s = {32'd0, SrcBE};
        end
        product_s  = extA_s * extB_s;
        aNeg_s     = (MDUOpE == MDU_DIV) && SrcAE[31];
        bNeg_s     = (MDUOpE == MDU_DIV) && SrcBE[31];
        magA_s     = aNeg_s ? (32'd0 - SrcAE) : SrcAE;
        magB_s     = bNeg_s ? (32'd0 - SrcBE) : SrcBE;
        divStart_s = (state_r == ST_IDLE) && isDivOp(MDUOpE) && advance_s;
        divStep_s  = (state_r == ST_DIV) && advance_s;
    end

    mdu_div #(
        .STEPS(DIV_STEPS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (divStart_s),
        .step       (divStep_s),
        .dividendMag(magA_s),
        .divisorMag (magB_s),
        .dividendRaw(SrcAE),
        .quoNeg     (aNeg_s ^ bNeg_s),
        .remNeg     (aNeg_s),
        .done       (divDone_s),
        .quotient   (divQuo_s),
        .remainder  (divRem_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; a freeze outranks a flush.
    always_comb begin
        nextState_s = state_r;
        if (MemStall) begin
            nextState_s = state_r;
        end else if (ExceptDealM) begin
            nextState_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (isMulOp(MDUOpE)) begin
                        nextState_s = ST_MUL;
                    end else if (isDivOp(MDUOpE)) begin
                        nextState_s = ST_DIV;
                    end else begin
                        nextState_s = ST_IDLE;
                    end
                end
                ST_MUL:  nextState_s = ST_DONE;
                ST_DIV: begin
                    if (divDone_s) begin
                        nextState_s = ST_DONE;
                    end else begin
                        nextState_s = ST_DIV;
                    end
                end
                ST_DONE: nextState_s = ST_IDLE;
                default: nextState_s = ST_IDLE;
            endcase
        end
    end

    // Ready output: low while a long operation is starting or in flight.
    always_comb begin
        case (state_r)
            ST_IDLE: MDUReadyE = !(isMulOp(MDUOpE) || isDivOp(MDUOpE));
            ST_MUL:  MDUReadyE = 1'b0;
            ST_DIV:  MDUReadyE = 1'b0;
            ST_DONE: MDUReadyE = 1'b1;
            default: MDUReadyE = 1'b1;
        endcase
    end

    // Result staging and HI/LO; architectural registers change only at DONE exit or on MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rHi_r <= 32'd0;
            rLo_r <= 32'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
        end else if (advance_s) begin
            if ((state_r == ST_IDLE) && isMulOp(MDUOpE)) begin
                rHi_r <= product_s[63:32];
                rLo_r <= product_s[31:0];
            end else if (divDone_s) begin
                rHi_r <= divRem_s;
                rLo_r <= divQuo_s;
            end
            if (state_r == ST_DONE) begin
                hi_r <= rHi_r;
                lo_r <= rLo_r;
            end else if ((state_r == ST_IDLE) && (MDUOpE == MDU_MTHI)) begin
                hi_r <= SrcAE;
            end else if ((state_r == ST_IDLE) && (MDUOpE == MDU_MTLO)) begin
                lo_r <= SrcAE;
            end
        end
    end

    assign HiE = hi_r;
    assign LoE = lo_r;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage. It owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It drives `MDUReadyE`, the signal the hazard unit uses to hold IF/ID/EX and bubble MEM. It honours the same `MemStall` freeze and `ExceptDealM` flush that the hazard unit applies to the pipeline.

## Interface
- `DIV_STEPS`, default 32: quotient bits produced per division, one per cycle. Fixed at 32 for the 32-bit datapath.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `MDUOpE  in  3`: EX-stage operation. 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
- `SrcAE  in  32`: rs operand, already forwarded. Dividend or multiplicand; data source for MTHI/MTLO.
- `SrcBE  in  32`: rt operand, already forwarded. Divisor or multiplier.
- `MemStall  in  1`: global freeze. While high, no state, counter, internal register or HI/LO changes.
- `ExceptDealM  in  1`: exception flush. Aborts the operation in EX and suppresses its HI/LO write.
- `MDUReadyE  out  1`: 0 while an operation occupies EX unfinished.
- `HiE  out  32`: current HI register, read by MFHI in EX.
- `LoE  out  32`: current LO register, read by MFLO in EX.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Reset:** state IDLE, counter 0, HI=LO=0, internal result registers 0.
- **`MDUReadyE`:**
  - 0 in MUL and DIV.
  - 0 in IDLE when `MDUOpE` ∈ {MULT, MULTU, DIV, DIVU}.
  - 1 otherwise.
- **IDLE with MULT/MULTU, `MemStall`=0, `ExceptDealM`=0:** register the 64-bit signed or unsigned product into the internal {rhi, rlo}, then go to MUL.
- **MUL:** one cycle, then go to DONE. MULT/MULTU therefore hold ready low for 2 cycles.
- **IDLE with DIV/DIVU:**
  - Latch operand magnitudes (DIV only; DIVU takes operands as-is).
  - Latch the quotient sign (signs differ) and the remainder sign (the dividend's sign).
  - Clear the partial remainder; counter=0; go to DIV.
- **DIV:** restoring step, one quotient bit per cycle. After step `DIV_STEPS`-1:
  - apply sign correction and write {rhi=remainder, rlo=quotient};
  - go to DONE.
- **Divide by zero (SrcBE=0):** rlo=32'hFFFFFFFF, rhi=SrcAE, no sign correction.
- **DIV of 0x80000000 by −1:** rlo=0x80000000, rhi=0 (wrap).
- **DONE:** `MDUReadyE`=1. At the edge with `MemStall`=0:
  - if `ExceptDealM`=0: HI←rhi, LO←rlo;
  - always go to IDLE.
- **MTHI/MTLO in IDLE:** ready=1. HI (or LO) ← SrcAE at the edge, when `MemStall`=0 and `ExceptDealM`=0.
- **`ExceptDealM`=1 with `MemStall`=0:** from any state, next state is IDLE. Internal registers are don't-care; HI/LO are untouched.
- **`MemStall`=1:** everything holds, including the DONE state and ready=1.
- **Precedence:** rst > MemStall > ExceptDealM > normal.

## Timing
- **MULT/MULTU:** cycle 0 (IDLE) ready=0; cycle 1 (MUL) ready=0; cycle 2 (DONE) ready=1. HI/LO updated from cycle 3.
- **DIV/DIVU:** cycle 0 ready=0; cycles 1–32 (DIV) ready=0; cycle 33 (DONE) ready=1. HI/LO updated from cycle 34.
- Each `MemStall` cycle extends either latency by exactly 1.
- HI/LO are written only at the DONE exit, so a flush before or in DONE never corrupts them.
- MFHI/MFLO entering EX right after completion, or right after MTHI/MTLO, sees the new value with no forwarding.
- **Back-to-back MDU ops:** DONE→IDLE, and the next op starts on its first EX cycle.
- **Input stability:** `MDUOpE`/`SrcAE`/`SrcBE` must stay stable while ready=0 (guaranteed by StallE). Only the IDLE-cycle values are used.

## Structure
- **Package `mdu_pkg`:** op encodings `MDU_NONE`…`MDU_MTLO`, state enum, `DIV_STEPS`.
- **Sub-module `mdu_div`:** iterative restoring divider (start, magnitudes, signs → 32-cycle core, done pulse, sign-corrected quotient/remainder). The top holds the FSM, the multiplier and HI/LO.

## Test plan
- MULT 0xFFFFFFFE×3 → ready 0,0,1; then HI=FFFFFFFF, LO=FFFFFFFA. MULTU with the same operands → HI=00000002, LO=FFFFFFFA.
- DIV −7/2 → ready low 33 cycles, high on cycle 33; then LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIVU 5/0 → LO=FFFFFFFF, HI=00000005. DIV 0x80000000/0xFFFFFFFF → LO=80000000, HI=0.
- Preset HI=LO=0x11111111; DIV started, `ExceptDealM` pulsed in cycle 10 → IDLE next cycle, ready=1 with op NONE, HI/LO still 0x11111111.
- MULT with `MemStall` high for 3 cycles in MUL and 2 in DONE → ready first high on cycle 5; HI/LO written exactly once, after the stall drops.
- `rst` in DIV cycle 20 → IDLE, HI=LO=0, ready=1 with op NONE. MTHI 0xABCD0000 then MTLO 0x1234 → HiE=ABCD0000, LoE=00001234.
